// File: rtl/l17_mat_ctrl.sv
// Chunk/output-group/pixel sequencer for the layer-17 16x16 MAC array, plus delayed BRAM2 write strobe.
// Issues one chunk per cycle in RUN, then drains the adder-tree pipeline before pulsing done.
module l17_mat_ctrl #(
   parameter int N_CHUNK  = 4,
   parameter int N_OG     = 4,
   parameter int N_PIX    = 64,
   parameter int PIPE_LAT = 3,
   parameter int AW       = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] w_addr,
   output logic [AW-1:0] bias_addr,
   output logic          load,
   output logic [2:0]    U,
   output logic [2:0]    u_Reg1,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   localparam int OGW = (N_OG  > 1) ? $clog2(N_OG)  : 1;
   localparam int PXW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_n;

   logic [2:0]      r_chunk;
   logic [OGW-1:0]  r_og;
   logic [PXW-1:0]  r_pix;
   logic [3:0]      r_dcnt;

   logic [2:0]      w_chunk_n;
   logic [OGW-1:0]  w_og_n;
   logic [PXW-1:0]  w_pix_n;
   logic [3:0]      w_dcnt_n;

   logic            r_busy;
   logic            r_done;
   logic [AW-1:0]   r_rd_addr;
   logic [AW-1:0]   r_w_addr;
   logic [AW-1:0]   r_bias_addr;
   logic            r_load;
   logic [2:0]      r_u;
   logic [2:0]      r_u_reg1;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;

   logic            w_busy_n;
   logic            w_done_n;
   logic [AW-1:0]   w_rd_addr_n;
   logic [AW-1:0]   w_w_addr_n;
   logic [AW-1:0]   w_bias_addr_n;
   logic            w_load_n;
   logic [2:0]      w_u_n;
   logic            w_issue;
   logic            w_last_issue;
   logic            w_pv_in;
   logic [AW-1:0]   w_pa_in;

   // Write-pipeline stage 0 lines up with the issue cycle; wr_en is one register past the last stage.
   logic            r_pv [PIPE_LAT];
   logic [AW-1:0]   r_pa [PIPE_LAT];

   assign w_last_issue = (r_chunk == 3'(N_CHUNK - 1)) &&
                         (r_og    == OGW'(N_OG - 1))  &&
                         (r_pix   == PXW'(N_PIX - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (start)                          w_state_n = S_RUN;
         S_RUN:   if (w_last_issue)                   w_state_n = S_DRAIN;
         S_DRAIN: if (r_dcnt == 4'(PIPE_LAT - 1))     w_state_n = S_DONE;
         S_DONE:                                      w_state_n = S_IDLE;
         default:                                     w_state_n = S_IDLE;
      endcase
   end

   // Output logic: next values for the counters and the registered outputs
   always_comb begin
      w_chunk_n = '0;
      w_og_n    = '0;
      w_pix_n   = '0;
      if (r_state == S_RUN && w_state_n == S_RUN) begin
         w_chunk_n = r_chunk;
         w_og_n    = r_og;
         w_pix_n   = r_pix;
         if (r_chunk == 3'(N_CHUNK - 1)) begin
            w_chunk_n = '0;
            if (r_og == OGW'(N_OG - 1)) begin
               w_og_n  = '0;
               w_pix_n = r_pix + PXW'(1);
            end else begin
               w_og_n  = r_og + OGW'(1);
            end
         end else begin
            w_chunk_n = r_chunk + 3'd1;
         end
      end

      w_issue  = (w_state_n == S_RUN);
      w_dcnt_n = (r_state == S_DRAIN) ? r_dcnt + 4'd1 : 4'd0;
      w_busy_n = (w_state_n == S_RUN) || (w_state_n == S_DRAIN);
      w_done_n = (w_state_n == S_DONE);

      w_rd_addr_n   = r_rd_addr;
      w_w_addr_n    = r_w_addr;
      w_bias_addr_n = r_bias_addr;
      w_load_n      = 1'b0;
      w_u_n         = 3'd0;
      if (w_issue) begin
         w_rd_addr_n   = AW'(w_pix_n) * AW'(N_CHUNK) + AW'(w_chunk_n);
         w_w_addr_n    = AW'(w_og_n)  * AW'(N_CHUNK) + AW'(w_chunk_n);
         w_bias_addr_n = AW'(w_og_n);
         w_load_n      = (w_chunk_n == 3'd0);
         w_u_n         = w_chunk_n;
      end

      w_pv_in = w_issue && (w_chunk_n == 3'(N_CHUNK - 1));
      w_pa_in = AW'(w_pix_n) * AW'(N_OG) + AW'(w_og_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chunk     <= '0;
         r_og        <= '0;
         r_pix       <= '0;
         r_dcnt      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_addr   <= '0;
         r_w_addr    <= '0;
         r_bias_addr <= '0;
         r_load      <= 1'b0;
         r_u         <= '0;
         r_u_reg1    <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_pa[i] <= '0;
         end
      end else begin
         r_chunk     <= w_chunk_n;
         r_og        <= w_og_n;
         r_pix       <= w_pix_n;
         r_dcnt      <= w_dcnt_n;
         r_busy      <= w_busy_n;
         r_done      <= w_done_n;
         r_rd_addr   <= w_rd_addr_n;
         r_w_addr    <= w_w_addr_n;
         r_bias_addr <= w_bias_addr_n;
         r_load      <= w_load_n;
         r_u         <= w_u_n;
         r_u_reg1    <= r_u;
         r_pv[0]     <= w_pv_in;
         r_pa[0]     <= w_pa_in;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
         end
         r_wr_en <= r_pv[PIPE_LAT-1];
         if (r_pv[PIPE_LAT-1]) begin
            r_wr_addr <= r_pa[PIPE_LAT-1];
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_addr   = r_rd_addr;
   assign w_addr    = r_w_addr;
   assign bias_addr = r_bias_addr;
   assign load      = r_load;
   assign U         = r_u;
   assign u_Reg1    = r_u_reg1;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;

endmodule
